// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty,
// occupancy count, sticky error flags and standard or FWFT read.
module sync_fifo_flags #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   clr_err,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Reject impossible geometries/thresholds at elaboration.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AE_THRESH <= 0 || AE_THRESH >= AF_THRESH ||
      AF_THRESH > DEPTH || DATA_W < 1) begin : g_bad_cfg
    $error("sync_fifo_flags: illegal parameter set");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic rd_acc;
  logic wr_acc;
  logic wr_drop;
  logic rd_bad;

  // Flags decode straight from the registered occupancy.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    count        = count_q;
    overflow     = ovf_q;
    underflow    = unf_q;
  end

  // Accept decisions; a pop frees the slot a full-FIFO write needs.
  always_comb begin
    rd_acc  = rd_en && !empty;
    wr_acc  = wr_en && (!full || rd_acc);
    wr_drop = wr_en && !wr_acc;
    rd_bad  = rd_en && empty;
  end

  // Next-state for pointers, occupancy and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A fresh error beats a coincident clear.
    ovf_d = (ovf_q && !clr_err) || wr_drop;
    unf_d = (unf_q && !clr_err) || rd_bad;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word presented directly; masked to zero when empty
    // so nothing stale is ever visible after reset.
    always_comb begin
      valid    = !empty;
      data_out = empty ? '0 : mem_q[rd_ptr_q];
    end
  end else begin : g_std
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              vld_q, vld_d;

    // Registered read port: capture head on each accepted pop.
    always_comb begin
      dout_d = dout_q;
      vld_d  = rd_acc;
      if (rd_acc) dout_d = mem_q[rd_ptr_q];
    end

    // Read data/valid registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        dout_q <= dout_d;
        vld_q  <= vld_d;
      end
    end

    // Drive the outputs from the read registers.
    always_comb begin
      valid    = vld_q;
      data_out = dout_q;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Scoreboard bench: standard and FWFT instances share stimulus,
// a queue-based model predicts flags and read data.
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en, rd_en, clr_err;
  logic [DW-1:0] data_in;

  logic [DW-1:0] dout0, dout1;
  logic          vld0, vld1;
  logic          full0, full1, empty0, empty1;
  logic          af0, af1, ae0, ae1;
  logic [CW-1:0] cnt0, cnt1;
  logic          ovf0, ovf1, unf0, unf1;

  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout0), .valid(vld0),
    .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .clr_err(clr_err),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_flags #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout1), .valid(vld1),
    .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .clr_err(clr_err),
    .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf, m_unf;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = mq.size();
    chk("count0", 32'(cnt0), 32'(n));
    chk("count1", 32'(cnt1), 32'(n));
    chk("full0", 32'(full0), 32'(n == DP));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("af0", 32'(af0), 32'(n >= DP - 2));
    chk("ae0", 32'(ae0), 32'(n <= 2));
    chk("full1", 32'(full1), 32'(n == DP));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("af1", 32'(af1), 32'(n >= DP - 2));
    chk("ae1", 32'(ae1), 32'(n <= 2));
    chk("ovf0", 32'(ovf0), 32'(m_ovf));
    chk("unf0", 32'(unf0), 32'(m_unf));
    chk("ovf1", 32'(ovf1), 32'(m_ovf));
    chk("unf1", 32'(unf1), 32'(m_unf));
    chk("fwft_valid", 32'(vld1), 32'(n != 0));
    chk("fwft_data", 32'(dout1), n != 0 ? 32'(mq[0]) : 32'd0);
  endtask

  // One clock of stimulus; the model advances on the same edge.
  task automatic cyc(input bit w, input logic [DW-1:0] d,
                     input bit r, input bit c);
    bit ra, wa;
    wr_en   = w;
    data_in = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    ra = r && mq.size() > 0;
    wa = w && (mq.size() < DP || ra);
    m_ovf = (m_ovf && !c) || (w && !wa);
    m_unf = (m_unf && !c) || (r && mq.size() == 0);
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    #1;
    check_state();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0);
  endtask

  // Reset applied between edges; outputs must clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    mq.delete();
    exp_q.delete();
    m_ovf = 0;
    m_unf = 0;
    check_state();
    chk("rst_valid0", 32'(vld0), 32'd0);
    chk("rst_dout0", 32'(dout0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every valid from the standard-read DUT pops one
  // expected word from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && vld0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(vld0), 32'd0);
        end else begin
          chk("rd_data0", 32'(dout0), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    data_in = '0;
    m_ovf   = 0;
    m_unf   = 0;
    #1;
    check_state();
    chk("rst_valid0", 32'(vld0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Fill then drain in order.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    idle(2);

    // Overflow on a full FIFO; dropped word must never appear.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    idle(3);
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    idle(2);

    // Underflow, then read+write into empty FIFO.
    cyc(0, 8'h00, 1, 0);
    cyc(1, 8'h55, 1, 0);
    cyc(0, 8'h00, 1, 0);
    cyc(0, 8'h00, 0, 1);
    // Clear coinciding with a new error keeps the flag set.
    cyc(0, 8'h00, 1, 1);
    cyc(0, 8'h00, 0, 1);
    idle(2);

    // Pointer wrap.
    for (int i = 0; i < 12; i++) cyc(1, 8'(i), 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 12; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 8'h00, 1, 0);
    idle(2);

    // Simultaneous read+write while full.
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(1, 8'h77, 1, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    idle(2);

    // Reset mid-burst, then refill and check the FWFT head.
    for (int i = 0; i < 9; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    idle(2);

    // Randomized traffic with drifting write/read bias.
    for (int ph = 0; ph < 4; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 75 : 35;
      rp = (ph % 2 == 0) ? 35 : 75;
      for (int i = 0; i < 150; i++) begin
        cyc($urandom_range(0, 99) < wp,
            8'($urandom),
            $urandom_range(0, 99) < rp,
            $urandom_range(0, 15) == 0);
      end
    end
    for (int i = 0; i < 20; i++) cyc(0, 8'h00, 1, 0);
    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
